// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 memory subsystem: MAR/MDR, wait-stated RAM, keyboard/display MMIO
module lc3_mem_ctrl #(
  parameter int DATA_W = 16,
  parameter int RAM_AW = 10,
  parameter int WAIT_STATES = 2,
  parameter logic [DATA_W-1:0] KBSR_ADDR = 16'hFE00,
  parameter logic [DATA_W-1:0] KBDR_ADDR = 16'hFE02,
  parameter logic [DATA_W-1:0] DSR_ADDR  = 16'hFE04,
  parameter logic [DATA_W-1:0] DDR_ADDR  = 16'hFE06
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] Bus,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              selMDR,
  input  logic              memEN,
  input  logic              memWE,
  output logic              R,
  output logic [DATA_W-1:0] MDROut,
  output logic [DATA_W-1:0] MAROut,
  input  logic [7:0]        kbd_data,
  input  logic              kbd_valid,
  output logic              kbd_irq,
  output logic [7:0]        disp_data,
  output logic              disp_valid,
  input  logic              disp_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

  stateT             state, nextState;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] mar, mdr;
  logic [DATA_W-1:0] rdData;
  logic              kbsrReady, kbsrIe;
  logic [7:0]        kbdr;
  logic [7:0]        dispData;
  logic              dispValid;
  logic [DATA_W-1:0] ram [0:(1<<RAM_AW)-1];

  logic              marIsMmio, addrIsMmio, addrInRam;
  logic [RAM_AW-1:0] ramIdx;
  logic              doneWrite, doneRead, kbdRead, kbdAccept;

  assign marIsMmio  = (mar == KBSR_ADDR) || (mar == KBDR_ADDR) ||
                      (mar == DSR_ADDR)  || (mar == DDR_ADDR);
  assign addrIsMmio = (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
                      (addr == DSR_ADDR)  || (addr == DDR_ADDR);
  assign addrInRam  = (addr >> RAM_AW) == '0;
  assign ramIdx     = addr[RAM_AW-1:0];

  assign doneWrite = (state == DONE) && we;
  assign doneRead  = (state == DONE) && !we;
  assign kbdRead   = doneRead && (addr == KBDR_ADDR);
  // A char arriving in the same cycle the old one is consumed still gets in.
  assign kbdAccept = kbd_valid && (!kbsrReady || kbdRead);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    R         = 1'b0;
    case (state)
      IDLE: if (memEN) nextState = (marIsMmio || WAIT_STATES == 0) ? DONE : WAIT;
      WAIT: if (cnt == 4'd1) nextState = DONE;
      DONE: begin
        R         = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    rdData = '0;
    if (addr == KBSR_ADDR)      rdData[15:14] = {kbsrReady, kbsrIe};
    else if (addr == KBDR_ADDR) rdData[7:0]   = kbdr;
    else if (addr == DSR_ADDR)  rdData[15]    = !dispValid;
    else if (addr == DDR_ADDR)  rdData[7:0]   = dispData;
    else if (addrInRam)         rdData        = ram[ramIdx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar       <= '0;
      mdr       <= '0;
      cnt       <= '0;
      addr      <= '0;
      we        <= 1'b0;
      kbsrReady <= 1'b0;
      kbsrIe    <= 1'b0;
      kbdr      <= '0;
      dispData  <= '0;
      dispValid <= 1'b0;
    end else begin
      if (ldMAR) mar <= Bus;
      if (ldMDR) mdr <= selMDR ? rdData : Bus;

      if (state == IDLE && memEN) begin
        addr <= mar;
        we   <= memWE;
        cnt  <= CNT_INIT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end

      if (kbdAccept) begin
        kbdr      <= kbd_data;
        kbsrReady <= 1'b1;
      end else if (kbdRead) begin
        kbsrReady <= 1'b0;
      end
      if (doneWrite && addr == KBSR_ADDR) kbsrIe <= mdr[14];

      // DSR ready is simply the inverse of a pending display character.
      if (disp_ack && dispValid) begin
        dispValid <= 1'b0;
      end else if (doneWrite && addr == DDR_ADDR && !dispValid) begin
        dispData  <= mdr[7:0];
        dispValid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && doneWrite && !addrIsMmio && addrInRam) ram[ramIdx] <= mdr;
  end

  assign MDROut     = mdr;
  assign MAROut     = mar;
  assign kbd_irq    = kbsrReady & kbsrIe;
  assign disp_data  = dispData;
  assign disp_valid = dispValid;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb/tb_lc3_mem_ctrl.sv - directed self-checking bench for lc3_mem_ctrl
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Bus;
  logic        ldMAR, ldMDR, selMDR, memEN, memWE;
  logic        R;
  logic [15:0] MDROut, MAROut;
  logic [7:0]  kbd_data;
  logic        kbd_valid;
  logic        kbd_irq;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        disp_ack;

  int checks = 0;
  int errors = 0;
  logic       injectOnDone = 1'b0;
  logic [7:0] injectChar = 8'h00;

  lc3_mem_ctrl #(.DATA_W(16), .RAM_AW(10), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .Bus(Bus), .ldMAR(ldMAR), .ldMDR(ldMDR),
    .selMDR(selMDR), .memEN(memEN), .memWE(memWE), .R(R), .MDROut(MDROut),
    .MAROut(MAROut), .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_irq(kbd_irq),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_ack(disp_ack)
  );

  always #5 clk = ~clk;

  // Full access: load MAR (and MDR for writes), pulse memEN, count cycles to R.
  task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w,
                        output logic [15:0] rv, output int lat);
    @(negedge clk); Bus = a; ldMAR = 1'b1;
    @(negedge clk); ldMAR = 1'b0;
    if (w) begin Bus = d; ldMDR = 1'b1; selMDR = 1'b0; end
    @(negedge clk); ldMDR = 1'b0; memEN = 1'b1; memWE = w;
    @(negedge clk); memEN = 1'b0; memWE = 1'b0; lat = 1;
    while (R !== 1'b1 && lat < 20) begin
      @(negedge clk); lat++;
    end
    if (R !== 1'b1) begin
      lat = 99;
    end else begin
      if (injectOnDone) begin kbd_valid = 1'b1; kbd_data = injectChar; end
      if (!w) begin ldMDR = 1'b1; selMDR = 1'b1; end
      @(negedge clk); ldMDR = 1'b0; selMDR = 1'b0; kbd_valid = 1'b0;
    end
    rv = MDROut;
  endtask

  task automatic kbd_inject(input logic [7:0] c);
    @(negedge clk); kbd_valid = 1'b1; kbd_data = c;
    @(negedge clk); kbd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; Bus = '0; ldMAR = 0; ldMDR = 0; selMDR = 0; memEN = 0; memWE = 0;
    kbd_data = '0; kbd_valid = 0; disp_ack = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (MAROut !== 16'h0000) begin errors++; $display("FAIL reset_mar got %h exp 0000", MAROut); end
    checks++; if (MDROut !== 16'h0000) begin errors++; $display("FAIL reset_mdr got %h exp 0000", MDROut); end
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL reset_r got %b exp 0", R); end
    checks++; if (disp_valid !== 1'b0 || kbd_irq !== 1'b0) begin
      errors++; $display("FAIL reset_flags got dv=%b irq=%b exp 0 0", disp_valid, kbd_irq);
    end
  endtask

  task automatic test_ram_rw;
    logic [15:0] rv; int lat;
    access(16'h0010, 16'hBEEF, 1'b1, rv, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ram_wr_lat got %0d exp 3", lat); end
    access(16'h0010, 16'h0000, 1'b0, rv, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL ram_rd_lat got %0d exp 3", lat); end
    checks++; if (rv !== 16'hBEEF) begin errors++; $display("FAIL ram_rd_data got %h exp beef", rv); end
    checks++; if (R !== 1'b0) begin errors++; $display("FAIL r_one_cycle got %b exp 0", R); end
  endtask

  task automatic test_keyboard;
    logic [15:0] rv; int lat;
    kbd_inject(8'h41);
    kbd_inject(8'h42);
    access(16'hFE00, 16'h0000, 1'b0, rv, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL mmio_lat got %0d exp 1", lat); end
    checks++; if (rv !== 16'h8000) begin errors++; $display("FAIL kbsr_ready got %h exp 8000", rv); end
    access(16'hFE02, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h0041) begin errors++; $display("FAIL kbdr_first got %h exp 0041", rv); end
    access(16'hFE00, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL kbsr_cleared got %h exp 0000", rv); end
  endtask

  task automatic test_kbd_irq;
    logic [15:0] rv; int lat;
    access(16'hFE00, 16'h4000, 1'b1, rv, lat);
    checks++; if (kbd_irq !== 1'b0) begin errors++; $display("FAIL irq_no_char got %b exp 0", kbd_irq); end
    kbd_inject(8'h55);
    checks++; if (kbd_irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", kbd_irq); end
    access(16'hFE02, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h0055) begin errors++; $display("FAIL irq_kbdr got %h exp 0055", rv); end
    checks++; if (kbd_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", kbd_irq); end
    access(16'hFE00, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h4000) begin errors++; $display("FAIL kbsr_ie got %h exp 4000", rv); end
    // A char arriving during the consuming read's DONE cycle must survive.
    kbd_inject(8'h61);
    injectOnDone = 1'b1; injectChar = 8'h62;
    access(16'hFE02, 16'h0000, 1'b0, rv, lat);
    injectOnDone = 1'b0;
    checks++; if (rv !== 16'h0061) begin errors++; $display("FAIL kbdr_race_old got %h exp 0061", rv); end
    checks++; if (kbd_irq !== 1'b1) begin errors++; $display("FAIL irq_race got %b exp 1", kbd_irq); end
    access(16'hFE02, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h0062) begin errors++; $display("FAIL kbdr_race_new got %h exp 0062", rv); end
  endtask

  task automatic test_display;
    logic [15:0] rv; int lat;
    access(16'hFE06, 16'h0058, 1'b1, rv, lat);
    checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h58) begin
      errors++; $display("FAIL ddr_write got dv=%b dd=%h exp 1 58", disp_valid, disp_data);
    end
    access(16'hFE04, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL dsr_busy got %h exp 0000", rv); end
    access(16'hFE06, 16'h0059, 1'b1, rv, lat);
    checks++; if (disp_data !== 8'h58) begin errors++; $display("FAIL ddr_drop got %h exp 58", disp_data); end
    access(16'hFE06, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h0058) begin errors++; $display("FAIL ddr_read got %h exp 0058", rv); end
    @(negedge clk); disp_ack = 1'b1;
    @(negedge clk); disp_ack = 1'b0;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_ack got %b exp 0", disp_valid); end
    access(16'hFE04, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h8000) begin errors++; $display("FAIL dsr_ready got %h exp 8000", rv); end
  endtask

  task automatic test_out_of_range;
    logic [15:0] rv; int lat;
    access(16'h0000, 16'h1111, 1'b1, rv, lat);
    access(16'h2000, 16'h0000, 1'b0, rv, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_rd_lat got %0d exp 3", lat); end
    checks++; if (rv !== 16'h0000) begin errors++; $display("FAIL oor_rd_data got %h exp 0000", rv); end
    access(16'h2000, 16'hDEAD, 1'b1, rv, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_lat got %0d exp 3", lat); end
    access(16'h0000, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h1111) begin errors++; $display("FAIL oor_no_alias got %h exp 1111", rv); end
  endtask

  task automatic test_reset_mid_access;
    logic [15:0] rv; int lat; int pulses;
    access(16'h0005, 16'hAAAA, 1'b1, rv, lat);
    access(16'hFE06, 16'h0033, 1'b1, rv, lat);
    @(negedge clk); Bus = 16'h0005; ldMAR = 1'b1;
    @(negedge clk); ldMAR = 1'b0; Bus = 16'h1234; ldMDR = 1'b1;
    @(negedge clk); ldMDR = 1'b0; memEN = 1'b1; memWE = 1'b1;
    @(negedge clk); memEN = 1'b0; memWE = 1'b0; reset = 1'b1;
    pulses = (R === 1'b1) ? 1 : 0;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (R === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_no_r got %0d exp 0", pulses); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL rst_disp got %b exp 0", disp_valid); end
    access(16'h0005, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'hAAAA) begin errors++; $display("FAIL rst_no_commit got %h exp aaaa", rv); end
    access(16'hFE04, 16'h0000, 1'b0, rv, lat);
    checks++; if (rv !== 16'h8000) begin errors++; $display("FAIL rst_dsr got %h exp 8000", rv); end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_keyboard();
    test_kbd_irq();
    test_display();
    test_out_of_range();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
